// File: rtl/cmp_sched_pkg.sv
// cmp_sched_pkg: shared types for the time-multiplexed
// comparator LED scheduler.
package cmp_sched_pkg;

  typedef enum logic [1:0] {
    IDLE,
    LOAD,
    SHOW,
    BLANK
  } state_e;

  typedef struct packed {
    logic red;
    logic green;
    logic blue;
  } rgb_t;

  localparam rgb_t RGB_OFF = '{red: 1'b0, green: 1'b0, blue: 1'b0};

endpackage

// File: rtl/rgb_cmp2.sv
// rgb_cmp2: magnitude comparator mapped onto RGB indicator bits.
// red = a<=b, green = a!=b, blue = a>=b.
module rgb_cmp2
  import cmp_sched_pkg::*;
#(
  parameter int WIDTH = 2
) (
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output rgb_t             rgb
);

  always_comb begin
    rgb       = RGB_OFF;
    rgb.red   = (a <= b);
    rgb.green = (a != b);
    rgb.blue  = (a >= b);
  end

endmodule

// File: rtl/cmp_led_scheduler.sv
// cmp_led_scheduler: round-robin one comparator + RGB LED over
// NCH operand channels with dwell, blanking gap and PWM dimming.
module cmp_led_scheduler
  import cmp_sched_pkg::*;
#(
  parameter int NCH      = 4,
  parameter int WIDTH    = 2,
  parameter int DWELL    = 1000,
  parameter int GAP      = 100,
  parameter int PWM_BITS = 4
) (
  input  logic                                clk,
  input  logic                                rst_n,
  input  logic                                en,
  input  logic [NCH*WIDTH-1:0]                ch_a,
  input  logic [NCH*WIDTH-1:0]                ch_b,
  input  logic [NCH-1:0]                      ch_valid,
  input  logic [PWM_BITS-1:0]                 duty,
  output logic                                red,
  output logic                                green,
  output logic                                blue,
  output logic [$clog2(NCH > 1 ? NCH : 2)-1:0] ch_sel,
  output logic                                frame_done
);

  localparam int SW  = $clog2(NCH > 1 ? NCH : 2);
  localparam int LIM = (DWELL > GAP) ? DWELL : GAP;
  localparam int CW  = $clog2(LIM + 1);

  localparam logic [CW-1:0] DW_END  = CW'(DWELL - 1);
  localparam logic [CW-1:0] GAP_END = CW'(GAP - 1);
  localparam logic [SW:0]   NCH_W   = (SW + 1)'(NCH);

  state_e              state, state_d;
  logic [CW-1:0]       cnt, cnt_d;
  logic [SW-1:0]       last, pick;
  logic [SW:0]         cand;
  logic                found, take;
  logic [WIDTH-1:0]    a_pick, b_pick;
  logic [WIDTH-1:0]    snap_a, snap_b;
  logic [PWM_BITS-1:0] pwm_cnt;
  logic                pwm_on;
  rgb_t                cmp, led;

  // First valid channel after last, wrapping modulo NCH.
  always_comb begin
    pick  = '0;
    found = 1'b0;
    cand  = '0;
    for (int i = 1; i <= NCH; i++) begin
      cand = {1'b0, last} + (SW + 1)'(i);
      if (cand >= NCH_W) cand = cand - NCH_W;
      if (!found && ch_valid[cand[SW-1:0]]) begin
        found = 1'b1;
        pick  = cand[SW-1:0];
      end
    end
  end

  always_comb begin
    a_pick = '0;
    b_pick = '0;
    for (int i = 0; i < NCH; i++) begin
      if (pick == SW'(i)) begin
        a_pick = ch_a[i*WIDTH +: WIDTH];
        b_pick = ch_b[i*WIDTH +: WIDTH];
      end
    end
  end

  always_comb begin
    state_d = state;
    cnt_d   = cnt;
    take    = 1'b0;
    if (!en) begin
      state_d = IDLE;
      cnt_d   = '0;
    end else begin
      unique case (state)
        IDLE: begin
          state_d = LOAD;
          cnt_d   = '0;
        end
        LOAD: begin
          cnt_d = '0;
          if (found) begin
            state_d = SHOW;
            take    = 1'b1;
          end
        end
        SHOW: begin
          if (cnt == DW_END) begin
            state_d = BLANK;
            cnt_d   = '0;
          end else begin
            cnt_d = cnt + 1'b1;
          end
        end
        BLANK: begin
          if (cnt == GAP_END) begin
            state_d = LOAD;
            cnt_d   = '0;
          end else begin
            cnt_d = cnt + 1'b1;
          end
        end
        default: begin
          state_d = IDLE;
          cnt_d   = '0;
        end
      endcase
    end
  end

  rgb_cmp2 #(
    .WIDTH(WIDTH)
  ) u_cmp (
    .a  (snap_a),
    .b  (snap_b),
    .rgb(cmp)
  );

  assign pwm_on = (pwm_cnt < duty) || (&duty);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state      <= IDLE;
      cnt        <= '0;
      last       <= SW'(NCH - 1);
      ch_sel     <= '0;
      frame_done <= 1'b0;
      snap_a     <= '0;
      snap_b     <= '0;
      pwm_cnt    <= '0;
      led        <= RGB_OFF;
    end else begin
      state      <= state_d;
      cnt        <= cnt_d;
      pwm_cnt    <= pwm_cnt + 1'b1;
      frame_done <= take && (pick <= last);
      if (take) begin
        last   <= pick;
        ch_sel <= pick;
        snap_a <= a_pick;
        snap_b <= b_pick;
      end
      // Dropping en blanks the LED on the very next cycle.
      if (en && state == SHOW && pwm_on) led <= cmp;
      else                               led <= RGB_OFF;
    end
  end

  assign red   = led.red;
  assign green = led.green;
  assign blue  = led.blue;

endmodule

// File: tb/tb_cmp_led_scheduler.sv
// tb_cmp_led_scheduler: scenario tasks plus randomized traffic,
// checked against a slot-timeline reference model.
module tb_cmp_led_scheduler;

  localparam int NCH   = 4;
  localparam int WIDTH = 2;
  localparam int DWELL = 4;
  localparam int GAP   = 2;
  localparam int PB    = 2;
  localparam int PER   = 1 + DWELL + GAP;

  logic             clk = 1'b0;
  logic             rst_n = 1'b0;
  logic             en = 1'b0;
  logic [NCH*WIDTH-1:0] ch_a = '0;
  logic [NCH*WIDTH-1:0] ch_b = '0;
  logic [NCH-1:0]   ch_valid = '0;
  logic [PB-1:0]    duty = '1;
  logic             red, green, blue;
  logic [1:0]       ch_sel;
  logic             frame_done;

  int n_tests = 0;
  int n_fail  = 0;

  always #5 clk = ~clk;

  cmp_led_scheduler #(
    .NCH(NCH), .WIDTH(WIDTH), .DWELL(DWELL),
    .GAP(GAP), .PWM_BITS(PB)
  ) dut (
    .clk(clk), .rst_n(rst_n), .en(en),
    .ch_a(ch_a), .ch_b(ch_b), .ch_valid(ch_valid),
    .duty(duty), .red(red), .green(green), .blue(blue),
    .ch_sel(ch_sel), .frame_done(frame_done)
  );

  // Model: pos is the place inside a channel slot of length
  // PER (0 = selection poll, 1..DWELL shown, rest blank),
  // -1 when idle. tick is cycles since reset (PWM phase).
  typedef struct {
    int         pos;
    int         tick;
    int         last;
    int         sel;
    logic [2:0] rgb;
    logic       fd;
    logic [1:0] a;
    logic [1:0] b;
  } model_t;

  model_t ms;

  function automatic logic [2:0] cmp_ref(logic [1:0] a, logic [1:0] b);
    return {a <= b, a != b, a >= b};
  endfunction

  function automatic model_t model_rst();
    model_t r;
    r.pos = -1; r.tick = 0; r.last = NCH - 1; r.sel = 0;
    r.rgb = 3'b000; r.fd = 1'b0; r.a = '0; r.b = '0;
    return r;
  endfunction

  function automatic model_t step(model_t s);
    model_t n = s;
    int nxt = -1;
    bit pwm;
    pwm = ((s.tick % (1 << PB)) < int'(duty)) || (duty == '1);
    n.rgb = (en && s.pos >= 1 && s.pos <= DWELL && pwm) ?
            cmp_ref(s.a, s.b) : 3'b000;
    n.fd = 1'b0;
    n.tick = s.tick + 1;
    if (!en) n.pos = -1;
    else if (s.pos < 0) n.pos = 0;
    else if (s.pos == 0) begin
      for (int j = NCH; j >= 1; j--)
        if (ch_valid[(s.last + j) % NCH]) nxt = (s.last + j) % NCH;
      if (nxt >= 0) begin
        n.fd = (nxt <= s.last);
        n.last = nxt; n.sel = nxt; n.pos = 1;
        n.a = ch_a[nxt*WIDTH +: WIDTH];
        n.b = ch_b[nxt*WIDTH +: WIDTH];
      end
    end else n.pos = (s.pos == PER - 1) ? 0 : s.pos + 1;
    return n;
  endfunction

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) ms <= model_rst();
    else        ms <= step(ms);
  end

  task automatic set_ch(input int i, input logic [1:0] a, input logic [1:0] b);
    ch_a[i*WIDTH +: WIDTH] = a;
    ch_b[i*WIDTH +: WIDTH] = b;
  endtask

  task automatic do_reset();
    en = 1'b0;
    rst_n = 1'b0;
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
  endtask

  task automatic load_compare_set();
    set_ch(0, 2'd1, 2'd2);
    set_ch(1, 2'd2, 2'd2);
    set_ch(2, 2'd3, 2'd0);
    set_ch(3, 2'd0, 2'd3);
  endtask

  task automatic test_reset();
    rst_n = 1'b0; en = 1'b0;
    repeat (2) @(negedge clk);
    n_tests++;
    if ({red, green, blue, ch_sel, frame_done} !== 6'b0) begin
      n_fail++;
      $display("FAIL reset_vals got %b want 000000",
               {red, green, blue, ch_sel, frame_done});
    end
    rst_n = 1'b1;
    repeat (3) begin
      @(negedge clk);
      n_tests++;
      if ({red, green, blue, ch_sel, frame_done} !== 6'b0) begin
        n_fail++;
        $display("FAIL idle_off got %b want 000000",
                 {red, green, blue, ch_sel, frame_done});
      end
    end
  endtask

  task automatic test_compare();
    logic [2:0] want [4] = '{3'b110, 3'b101, 3'b011, 3'b110};
    do_reset();
    duty = '1; ch_valid = 4'hF;
    load_compare_set();
    en = 1'b1;
    for (int c = 1; c <= 8 * PER + 2; c++) begin
      @(negedge clk);
      n_tests++;
      if ({red, green, blue, ch_sel, frame_done} !==
          {ms.rgb, 2'(ms.sel), ms.fd}) begin
        n_fail++;
        $display("FAIL compare_model c=%0d got %b want %b", c,
                 {red, green, blue, ch_sel, frame_done},
                 {ms.rgb, 2'(ms.sel), ms.fd});
      end
      for (int k = 0; k < 8; k++) begin
        if (c == 3 + PER * k) begin
          n_tests++;
          if ({red, green, blue} !== want[k % 4]) begin
            n_fail++;
            $display("FAIL compare_rgb k=%0d got %b want %b", k,
                     {red, green, blue}, want[k % 4]);
          end
        end
        if (c == 2 + PER * k) begin
          n_tests++;
          if ({ch_sel, frame_done} !== {2'(k % 4), k % 4 == 0}) begin
            n_fail++;
            $display("FAIL compare_sel k=%0d got %b want %b", k,
                     {ch_sel, frame_done}, {2'(k % 4), k % 4 == 0});
          end
        end
      end
    end
  endtask

  task automatic test_mask_skip();
    do_reset();
    duty = '1; ch_valid = 4'b1010;
    load_compare_set();
    en = 1'b1;
    for (int c = 1; c <= 4 * PER + 2; c++) begin
      @(negedge clk);
      n_tests++;
      if ({red, green, blue, ch_sel, frame_done} !==
          {ms.rgb, 2'(ms.sel), ms.fd}) begin
        n_fail++;
        $display("FAIL mask_model c=%0d got %b want %b", c,
                 {red, green, blue, ch_sel, frame_done},
                 {ms.rgb, 2'(ms.sel), ms.fd});
      end
      for (int k = 0; k < 4; k++) begin
        if (c == 2 + PER * k) begin
          n_tests++;
          if ({ch_sel, frame_done} !==
              {(k % 2 == 0) ? 2'd1 : 2'd3, k % 2 == 0}) begin
            n_fail++;
            $display("FAIL mask_order k=%0d got %b want %b", k,
                     {ch_sel, frame_done},
                     {(k % 2 == 0) ? 2'd1 : 2'd3, k % 2 == 0});
          end
        end
      end
    end
  endtask

  task automatic test_snapshot();
    do_reset();
    duty = '1; ch_valid = 4'hF;
    load_compare_set();
    en = 1'b1;
    for (int c = 1; c <= 4 * PER + 4; c++) begin
      @(negedge clk);
      if (c >= 3 && c <= 6) begin
        n_tests++;
        if ({red, green, blue} !== 3'b110) begin
          n_fail++;
          $display("FAIL snap_hold c=%0d got %b want 110", c,
                   {red, green, blue});
        end
      end
      if (c == 3 + 4 * PER) begin
        n_tests++;
        if ({red, green, blue} !== 3'b011) begin
          n_fail++;
          $display("FAIL snap_next got %b want 011", {red, green, blue});
        end
      end
      if (c == 4) set_ch(0, 2'd3, 2'd2);
    end
  endtask

  task automatic test_pwm();
    int on_win [4];
    int on_total;
    do_reset();
    duty = 2'd1; ch_valid = 4'b0001;
    set_ch(0, 2'd2, 2'd2);
    en = 1'b1;
    on_win = '{0, 0, 0, 0};
    for (int c = 1; c <= 4 * PER + 2; c++) begin
      @(negedge clk);
      n_tests++;
      if ({red, green, blue, ch_sel, frame_done} !==
          {ms.rgb, 2'(ms.sel), ms.fd}) begin
        n_fail++;
        $display("FAIL pwm_model c=%0d got %b want %b", c,
                 {red, green, blue, ch_sel, frame_done},
                 {ms.rgb, 2'(ms.sel), ms.fd});
      end
      for (int k = 0; k < 4; k++)
        if (c >= 3 + PER * k && c <= 6 + PER * k && {red, green, blue} == 3'b101)
          on_win[k]++;
    end
    for (int k = 0; k < 4; k++) begin
      n_tests++;
      if (on_win[k] !== 1) begin
        n_fail++;
        $display("FAIL pwm_duty1 win=%0d got %0d want 1", k, on_win[k]);
      end
    end
    duty = 2'd0;
    on_total = 0;
    repeat (3 * PER) begin
      @(negedge clk);
      if ({red, green, blue} != 3'b000) on_total++;
    end
    n_tests++;
    if (on_total !== 0) begin
      n_fail++;
      $display("FAIL pwm_duty0 got %0d want 0", on_total);
    end
  endtask

  task automatic test_reset_enable();
    do_reset();
    duty = '1; ch_valid = 4'hF;
    load_compare_set();
    en = 1'b1;
    repeat (4) @(negedge clk);
    #2 rst_n = 1'b0;
    #1;
    n_tests++;
    if ({red, green, blue, ch_sel, frame_done} !== 6'b0) begin
      n_fail++;
      $display("FAIL async_rst got %b want 000000",
               {red, green, blue, ch_sel, frame_done});
    end
    @(negedge clk);
    rst_n = 1'b1;
    for (int c = 1; c <= 4; c++) begin
      @(negedge clk);
      if (c == 2) begin
        n_tests++;
        if ({ch_sel, frame_done} !== 3'b001) begin
          n_fail++;
          $display("FAIL rst_first_ch got %b want 001", {ch_sel, frame_done});
        end
      end
    end
    en = 1'b0;
    @(negedge clk);
    n_tests++;
    if ({red, green, blue} !== 3'b000) begin
      n_fail++;
      $display("FAIL en_drop got %b want 000", {red, green, blue});
    end
    repeat (3) @(negedge clk);
    en = 1'b1;
    for (int c = 1; c <= PER + 2; c++) begin
      @(negedge clk);
      n_tests++;
      if ({red, green, blue, ch_sel, frame_done} !==
          {ms.rgb, 2'(ms.sel), ms.fd}) begin
        n_fail++;
        $display("FAIL reen_model c=%0d got %b want %b", c,
                 {red, green, blue, ch_sel, frame_done},
                 {ms.rgb, 2'(ms.sel), ms.fd});
      end
      if (c == 2) begin
        n_tests++;
        if ({ch_sel, frame_done} !== 3'b010) begin
          n_fail++;
          $display("FAIL reen_resume got %b want 010", {ch_sel, frame_done});
        end
      end
    end
  endtask

  task automatic test_no_valid();
    do_reset();
    duty = '1; ch_valid = 4'b0000;
    load_compare_set();
    en = 1'b1;
    repeat (20) begin
      @(negedge clk);
      n_tests++;
      if ({red, green, blue, frame_done} !== 4'b0) begin
        n_fail++;
        $display("FAIL none_valid got %b want 0000",
                 {red, green, blue, frame_done});
      end
    end
    ch_valid = 4'b0100;
    @(negedge clk);
    n_tests++;
    if (ch_sel !== 2'd2) begin
      n_fail++;
      $display("FAIL none_then_ch2 got %0d want 2", ch_sel);
    end
  endtask

  task automatic test_random();
    do_reset();
    ch_valid = 4'hF;
    en = 1'b1;
    for (int c = 0; c < 1500; c++) begin
      @(negedge clk);
      n_tests++;
      if ({red, green, blue, ch_sel, frame_done} !==
          {ms.rgb, 2'(ms.sel), ms.fd}) begin
        n_fail++;
        $display("FAIL random_model c=%0d got %b want %b", c,
                 {red, green, blue, ch_sel, frame_done},
                 {ms.rgb, 2'(ms.sel), ms.fd});
      end
      ch_a = NCH*WIDTH'($urandom);
      ch_b = NCH*WIDTH'($urandom);
      if ($urandom_range(0, 15) == 0) ch_valid = NCH'($urandom);
      if ($urandom_range(0, 30) == 0) duty = PB'($urandom);
      if ($urandom_range(0, 60) == 0) en = ~en;
    end
  endtask

  initial begin
    test_reset();
    test_compare();
    test_mask_skip();
    test_snapshot();
    test_pwm();
    test_reset_enable();
    test_no_valid();
    test_random();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/cmp_led_scheduler.md
# cmp_led_scheduler

Time-multiplexes one 2-bit magnitude comparator and its RGB indicator LED across up to NCH operand channels. Each channel is shown round-robin for a fixed dwell, separated by a blanking gap, with PWM brightness control. The block sits between the board switch/register inputs and the RGB LED pins, and replaces the one-comparator-per-LED arrangement.

## Interface
- NCH, 4: number of operand channels, ≥1
- WIDTH, 2: operand width per channel
- DWELL, 1000: cycles each channel is shown, ≥1
- GAP, 100: blanking cycles between channels, ≥1
- PWM_BITS, 4: brightness counter width
- clk  in  1  system clock; single clock domain
- rst_n  in  1  asynchronous, active-low reset
- en  in  1  scheduler enable
- ch_a  in  NCH*WIDTH  operand A; channel i at [i*WIDTH +: WIDTH]
- ch_b  in  NCH*WIDTH  operand B, same packing
- ch_valid  in  NCH  per-channel participation mask
- duty  in  PWM_BITS  brightness; 0 = off, all-ones = 100 %
- red, green, blue  out  1  registered LED drives, active-high
- ch_sel  out  $clog2(NCH) (min 1)  index of channel currently shown
- frame_done  out  1  one-cycle pulse on round-robin wrap

## Operation
- Comparator on snapshotted operands: red = (a ≤ b), green = (a ≠ b), blue = (a ≥ b). Results: a<b gives red+green; a=b gives red+blue; a>b gives green+blue.
- FSM states: IDLE, LOAD, SHOW, BLANK.
  - IDLE: LEDs off. Go to LOAD when en=1.
  - LOAD (1 cycle when successful):
    - Select the first index with ch_valid=1 after `last`, searching modulo NCH.
    - Snapshot that channel's a/b and update ch_sel and `last`; go to SHOW.
    - If no channel is valid, stay in LOAD with LEDs off and re-poll every cycle.
  - SHOW: exactly DWELL cycles. LED = comparator result AND pwm_on. Then go to BLANK.
  - BLANK: exactly GAP cycles with LEDs off. Then go to LOAD.
- en=0 in any state: go to IDLE on the next edge. The dwell/gap counter is cleared; `last` is kept.
- ch_a, ch_b and ch_valid changes are ignored outside LOAD.
- frame_done pulses in the LOAD cycle whose selected index ≤ the previous `last`. This includes the single-valid-channel case, where it pulses every selection.
- PWM:
  - pwm_cnt is free-running, increments every cycle, wraps at 2^PWM_BITS.
  - pwm_on = (pwm_cnt < duty) OR (duty all-ones).
  - duty is sampled every cycle.
- Dwell/gap counter: $clog2(max(DWELL,GAP)+1) bits. It loads 0 on state entry; the state exits when count = limit−1.

## Timing
- Reset values: state=IDLE, last=NCH−1 (first selection is channel 0), red=green=blue=0, ch_sel=0, frame_done=0, pwm_cnt=0, counter=0.
- Reset is asynchronous: assertion mid-SHOW forces LEDs off immediately.
- Outputs are registered: the LED value in cycle k+1 reflects state, snapshot and pwm_cnt in cycle k.
- en rising in cycle 0: LOAD in cycle 1, SHOW in cycles 2..DWELL+1, first LED drive in cycle 3.
- ch_sel and frame_done are registered from the LOAD cycle and are visible in the first SHOW cycle.
- Per-channel period = 1 + DWELL + GAP cycles. With all channels valid, a frame = NCH × that.

## Structure
- Package cmp_sched_pkg holds:
  - state_e enum (IDLE, LOAD, SHOW, BLANK);
  - rgb_t packed struct {red, green, blue};
  - constant RGB_OFF.
- Sub-module rgb_cmp2, parameterised by WIDTH: purely combinational a/b → rgb_t.
- Top level holds the FSM, dwell/gap counter, round-robin selector, PWM counter and output registers.

## Test plan
All scenarios use NCH=4, WIDTH=2, DWELL=4, GAP=2, PWM_BITS=2, duty=3, unless stated otherwise.
- Compare: channels (a,b) = (1,2), (2,2), (3,0), (0,3), all valid, en=1. Required rgb per SHOW: 110, 101, 011, 110. ch_sel = 0,1,2,3. frame_done pulses when ch_sel returns to 0.
- Mask skip: ch_valid=4'b1010. Required order 1,3,1,3. frame_done pulses with every selection of ch 1.
- Snapshot hold: change ch_a[0] from 1 to 3 mid-SHOW of ch 0. Required: rgb stays 110 for the full 4 cycles. The new value is used at the next ch 0 visit.
- PWM: duty=1, (a,b)=(2,2) on ch 0 only.
  - Required: LED on exactly 1 of every 4 cycles in SHOW.
  - duty=0 gives all-off.
  - BLANK always gives 000.
- Reset and enable:
  - Assert rst_n=0 mid-SHOW: outputs 0 without a clock edge.
  - After release with en=1: ch 0 is shown first.
  - Drop en mid-SHOW: LEDs 000 from the next cycle. Re-enable: resumes at the channel after `last`.
- No valid channels: ch_valid=0, en=1. Required: LEDs stay 000 and no frame_done. Setting ch_valid=4'b0100 gives ch_sel=2 in the next LOAD.
